// File: rtl/axi_wr_pkg.sv
// Shared types and helpers for the AXI-style register write slave.
package axi_wr_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   // Number of byte-offset bits below the register index.
   function automatic int unsigned calc_addr_lsb(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty tracked with an extra pointer MSB.
module sync_fifo #(
   parameter int unsigned width_g = 8,
   parameter int unsigned depth_g = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [width_g-1:0] wdata,
   output logic               full,
   input  logic               pop,
   output logic [width_g-1:0] rdata,
   output logic               empty
);

   localparam int unsigned PtrW = $clog2(depth_g);

   logic [PtrW:0]        wr_ptr_q, rd_ptr_q;
   logic [width_g-1:0]   mem_q [depth_g];
   logic                 do_push, do_pop;

   assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   // No pass-through: a push into a full FIFO is dropped even if a pop happens.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_q <= rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
   end

endmodule

// File: rtl/axi_wr_reg_slave.sv
// AXI-style write slave: buffers address/data beats, pairs them in order and
// commits each pair into a register bank with a buffered 2-bit response.
module axi_wr_reg_slave
   import axi_wr_pkg::*;
#(
   parameter int unsigned data_width_g = 32,
   parameter int unsigned num_regs_g   = 8,
   parameter int unsigned fifo_depth_g = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               waddr_valid,
   output logic                               waddr_ready,
   input  logic [data_width_g-1:0]            waddr_data,
   input  logic                               wdata_valid,
   output logic                               wdata_ready,
   input  logic [data_width_g-1:0]            wdata_data,
   output logic                               wresp_valid,
   input  logic                               wresp_ready,
   output logic [1:0]                         wresp_data,
   output logic [num_regs_g*data_width_g-1:0] regs_out,
   output logic [num_regs_g-1:0]              wr_strobe
);

   localparam int unsigned AddrLsb = calc_addr_lsb(data_width_g);
   localparam int unsigned IdxW    = (num_regs_g > 1) ? $clog2(num_regs_g) : 1;

   logic [data_width_g-1:0] addr_head, data_head, addr_idx;
   logic                    addr_full, addr_empty, data_full, data_empty;
   logic                    resp_full, resp_empty;
   logic                    commit, legal;
   logic [IdxW-1:0]         reg_idx;
   resp_t                   resp_in;

   logic [num_regs_g-1:0][data_width_g-1:0] regs_q;
   logic [num_regs_g-1:0]                   strobe_d, strobe_q;

   assign waddr_ready = !addr_full;
   assign wdata_ready = !data_full;
   assign wresp_valid = !resp_empty;

   sync_fifo #(
      .width_g (data_width_g),
      .depth_g (fifo_depth_g)
   ) u_addr_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (waddr_valid && waddr_ready),
      .wdata (waddr_data),
      .full  (addr_full),
      .pop   (commit),
      .rdata (addr_head),
      .empty (addr_empty)
   );

   sync_fifo #(
      .width_g (data_width_g),
      .depth_g (fifo_depth_g)
   ) u_data_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wdata_valid && wdata_ready),
      .wdata (wdata_data),
      .full  (data_full),
      .pop   (commit),
      .rdata (data_head),
      .empty (data_empty)
   );

   sync_fifo #(
      .width_g (2),
      .depth_g (fifo_depth_g)
   ) u_resp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (commit),
      .wdata (resp_in),
      .full  (resp_full),
      .pop   (wresp_ready),
      .rdata (wresp_data),
      .empty (resp_empty)
   );

   // Full is sampled before any same-cycle response pop, so a full response
   // FIFO always stalls the commit.
   assign commit   = !addr_empty && !data_empty && !resp_full;
   assign addr_idx = addr_head >> AddrLsb;
   assign legal    = (addr_head[AddrLsb-1:0] == '0) &&
                     (addr_idx < data_width_g'(num_regs_g));
   assign reg_idx  = addr_idx[IdxW-1:0];
   assign resp_in  = legal ? RESP_OKAY : RESP_SLVERR;

   always_comb begin
      strobe_d = '0;
      if (commit && legal) strobe_d[reg_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs_q   <= '0;
         strobe_q <= '0;
      end else begin
         strobe_q <= strobe_d;
         if (commit && legal) regs_q[reg_idx] <= data_head;
      end
   end

   assign regs_out  = regs_q;
   assign wr_strobe = strobe_q;

endmodule

// File: tb/tb_axi_wr_reg_slave.sv
// Directed self-checking bench for axi_wr_reg_slave (32-bit, 8 regs, depth 4).
module tb_axi_wr_reg_slave;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 8;
   localparam int unsigned FD = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             waddr_valid, waddr_ready;
   logic [DW-1:0]    waddr_data;
   logic             wdata_valid, wdata_ready;
   logic [DW-1:0]    wdata_data;
   logic             wresp_valid, wresp_ready;
   logic [1:0]       wresp_data;
   logic [NR*DW-1:0] regs_out;
   logic [NR-1:0]    wr_strobe;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axi_wr_reg_slave #(
      .data_width_g (DW),
      .num_regs_g   (NR),
      .fifo_depth_g (FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .waddr_valid (waddr_valid),
      .waddr_ready (waddr_ready),
      .waddr_data  (waddr_data),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata_data  (wdata_data),
      .wresp_valid (wresp_valid),
      .wresp_ready (wresp_ready),
      .wresp_data  (wresp_data),
      .regs_out    (regs_out),
      .wr_strobe   (wr_strobe)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] reg_at(input int i);
      return regs_out[i*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Present one address/data pair together and hold until both transfer.
   task automatic send_both(input logic [DW-1:0] a, input logic [DW-1:0] d);
      int b = 0;
      waddr_valid = 1'b1;
      waddr_data  = a;
      wdata_valid = 1'b1;
      wdata_data  = d;
      while (!(waddr_ready && wdata_ready) && b < 20) begin
         tick();
         b++;
      end
      if (b >= 20) check("send_timeout", 64'd1, 64'd0);
      tick();
      waddr_valid = 1'b0;
      wdata_valid = 1'b0;
   endtask

   function automatic logic [DW-1:0] bp_addr(input int i);
      return (i == 5) ? 32'h21 : 32'(i % 8) * 4;
   endfunction

   initial begin
      logic [1:0]    exp_resp;
      logic [DW-1:0] bp_exp [NR];
      int            sent, rcnt, b;
      logic          xfer, seen, drop;

      rst_n       = 1'b0;
      waddr_valid = 1'b0;
      waddr_data  = '0;
      wdata_valid = 1'b0;
      wdata_data  = '0;
      wresp_ready = 1'b1;
      do_reset();

      // Reset state
      check("rst_waddr_ready", waddr_ready, 1);
      check("rst_wdata_ready", wdata_ready, 1);
      check("rst_wresp_valid", wresp_valid, 0);
      check("rst_wresp_data", wresp_data, 0);
      check("rst_strobe", wr_strobe, 0);
      check("rst_regs", |regs_out, 0);

      // Single write: accepted on edge k, visible after edge k+1
      waddr_valid = 1'b1;
      waddr_data  = 32'h4;
      wdata_valid = 1'b1;
      wdata_data  = 32'hDEADBEEF;
      tick();
      waddr_valid = 1'b0;
      wdata_valid = 1'b0;
      check("single_not_yet", reg_at(1), 0);
      check("single_no_resp", wresp_valid, 0);
      tick();
      check("single_reg1", reg_at(1), 32'hDEADBEEF);
      check("single_strobe", wr_strobe, 8'b0000_0010);
      check("single_resp_valid", wresp_valid, 1);
      check("single_resp_data", wresp_data, 2'b00);
      tick();
      check("single_resp_gone", wresp_valid, 0);
      check("single_strobe_gone", wr_strobe, 0);

      // Data arrives 3 cycles before the address
      wdata_valid = 1'b1;
      wdata_data  = 32'h11;
      tick();
      wdata_valid = 1'b0;
      tick();
      tick();
      check("skew_no_early_commit", wresp_valid, 0);
      waddr_valid = 1'b1;
      waddr_data  = 32'h0;
      tick();
      waddr_valid = 1'b0;
      check("skew_wait_commit", wresp_valid, 0);
      tick();
      check("skew_reg0", reg_at(0), 32'h11);
      check("skew_strobe", wr_strobe, 8'b0000_0001);
      check("skew_resp", {wresp_valid, wresp_data}, 3'b100);
      tick();
      check("skew_one_resp", wresp_valid, 0);

      // Illegal addresses: out of range, then misaligned
      wresp_ready = 1'b0;
      send_both(32'h20, 32'hAA);
      check("ill_strobe_a", wr_strobe, 0);
      send_both(32'h2, 32'hBB);
      check("ill_strobe_b", wr_strobe, 0);
      tick();
      check("ill_strobe_c", wr_strobe, 0);
      check("ill_resp0", {wresp_valid, wresp_data}, 3'b110);
      check("ill_reg0", reg_at(0), 32'h11);
      check("ill_reg1", reg_at(1), 32'hDEADBEEF);
      for (int i = 2; i < NR; i++) check($sformatf("ill_reg%0d", i), reg_at(i), 0);
      wresp_ready = 1'b1;
      tick();
      check("ill_resp1", {wresp_valid, wresp_data}, 3'b110);
      tick();
      check("ill_drained", wresp_valid, 0);

      // Backpressure: 12 beats with responses blocked, beat 5 illegal
      wresp_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 15; c++) begin
         waddr_valid = (sent < 12);
         wdata_valid = (sent < 12);
         waddr_data  = bp_addr(sent);
         wdata_data  = 32'h100 + 32'(sent);
         xfer = waddr_valid && waddr_ready && wdata_ready;
         tick();
         if (xfer) sent++;
      end
      check("bp_accepted", sent, 8);
      check("bp_waddr_ready_low", waddr_ready, 0);
      check("bp_wdata_ready_low", wdata_ready, 0);
      check("bp_resp_pending", wresp_valid, 1);
      wresp_ready = 1'b1;
      rcnt = 0;
      b = 0;
      while (rcnt < 12 && b < 60) begin
         waddr_valid = (sent < 12);
         wdata_valid = (sent < 12);
         waddr_data  = bp_addr(sent);
         wdata_data  = 32'h100 + 32'(sent);
         if (wresp_valid) begin
            exp_resp = (rcnt == 5) ? 2'b10 : 2'b00;
            check($sformatf("bp_resp%0d", rcnt), wresp_data, exp_resp);
            rcnt++;
         end
         xfer = waddr_valid && waddr_ready && wdata_ready;
         tick();
         if (xfer) sent++;
         b++;
      end
      waddr_valid = 1'b0;
      wdata_valid = 1'b0;
      check("bp_resp_count", rcnt, 12);
      tick();
      check("bp_drained", wresp_valid, 0);
      bp_exp = '{32'h108, 32'h109, 32'h10A, 32'h10B, 32'h104, 32'h0, 32'h106, 32'h107};
      for (int i = 0; i < NR; i++) check($sformatf("bp_reg%0d", i), reg_at(i), bp_exp[i]);

      // Reset with three responses pending
      wresp_ready = 1'b0;
      send_both(32'h0, 32'h31);
      send_both(32'h4, 32'h32);
      send_both(32'h8, 32'h33);
      tick();
      tick();
      check("mrst_pending", wresp_valid, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_resp_valid", wresp_valid, 0);
      check("mrst_resp_data", wresp_data, 0);
      check("mrst_strobe", wr_strobe, 0);
      check("mrst_regs", |regs_out, 0);
      check("mrst_ready", {waddr_ready, wdata_ready}, 2'b11);
      wresp_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         seen = seen | wresp_valid | (|wr_strobe);
      end
      check("mrst_no_stale", seen, 0);

      // Back-to-back writes to regs 0..7
      drop = 1'b0;
      for (int t = 0; t < 11; t++) begin
         waddr_valid = (t < 8);
         wdata_valid = (t < 8);
         waddr_data  = 32'(t) * 4;
         wdata_data  = 32'h200 + 32'(t);
         if (t < 8 && !(waddr_ready && wdata_ready)) drop = 1'b1;
         if (t >= 2 && t <= 9) begin
            check($sformatf("b2b_strobe%0d", t), wr_strobe, 64'd1 << (t - 2));
            check($sformatf("b2b_resp%0d", t), {wresp_valid, wresp_data}, 3'b100);
         end else begin
            check($sformatf("b2b_strobe%0d", t), wr_strobe, 0);
            check($sformatf("b2b_noresp%0d", t), wresp_valid, 0);
         end
         tick();
      end
      waddr_valid = 1'b0;
      wdata_valid = 1'b0;
      check("b2b_no_ready_drop", drop, 0);
      for (int i = 0; i < NR; i++) check($sformatf("b2b_reg%0d", i), reg_at(i), 32'h200 + 32'(i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
